dcache_ctrl: RTL

//  Direct-mapped, write-through, no-write-allocate, blocking data cache between the MEM stage
//  (Address/Write_Data/MemRead/MemWrite from EX/MEM register) and backing data memory.

---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_if.sv | 21 ++
 rtl/dcache_line_store.sv | 61 ++++++
 rtl/dcache_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned DEF_NUM_LINES  = 16;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BYTE_OFF_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic int unsigned word_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned num_lines,
                                        input int unsigned line_words);
    return addr_w - BYTE_OFF_W - word_w(line_words) - idx_w(num_lines);
  endfunction

  // Field layout for the default geometry: [1:0] byte, word, index, tag.
  localparam int unsigned WORD_LSB = BYTE_OFF_W;
  localparam int unsigned IDX_LSB  = WORD_LSB + $clog2(DEF_LINE_WORDS);
  localparam int unsigned TAG_LSB  = IDX_LSB + $clog2(DEF_NUM_LINES);
  localparam int unsigned DEF_TAG_W = DEF_ADDR_W - TAG_LSB;

endpackage

// File: rtl/dcache_if.sv
// Backing-memory request/acknowledge bus between the data cache (master) and memory (slave).
interface dcache_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_line_store.sv
// Tag, valid and data arrays: one combinational read port, synchronous writes, valid clear-all on reset.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned TAG_W      = DEF_TAG_W,
  localparam int unsigned IDX_W     = idx_w(NUM_LINES),
  localparam int unsigned WORD_W    = word_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [31:0]       rd_data,

  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_index,

  input  logic              data_we,
  input  logic [IDX_W-1:0]  data_index,
  input  logic [WORD_W-1:0] data_word,
  input  logic [31:0]       data_wdata,

  input  logic              tag_we,
  input  logic [IDX_W-1:0]  tag_index,
  input  logic [TAG_W-1:0]  tag_wdata
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

  always_comb begin
    valid_d = valid_q;
    if (inv_en) valid_d[inv_index] = 1'b0;
    if (tag_we) valid_d[tag_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data carry no reset; valid bits alone decide whether contents are trusted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (tag_we)  tag_q[tag_index]              <= tag_wdata;
      if (data_we) data_q[data_index][data_word] <= data_wdata;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate blocking data cache for the MEM stage.
// Optional hit/miss counters enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       Write_Data,
  output logic [31:0]       Read_data,
  output logic              Stall,
  dcache_if.master          mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned WORD_W  = word_w(LINE_WORDS);
  localparam int unsigned IDX_W   = idx_w(NUM_LINES);
  localparam int unsigned TAG_W   = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
  localparam int unsigned IDX_LSB = BYTE_OFF_W + WORD_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [WORD_W-1:0] lk_word;
  logic [IDX_W-1:0]  lk_index;
  logic [TAG_W-1:0]  lk_tag;
  logic [WORD_W-1:0] fill_word;
  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;
  logic              fill_last;

  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              hit;
  logic              lookup;

  logic              inv_en;
  logic              data_we;
  logic [IDX_W-1:0]  data_index;
  logic [WORD_W-1:0] data_word;
  logic [31:0]       data_wdata;
  logic              tag_we;

  assign lk_word    = Address[IDX_LSB-1:BYTE_OFF_W];
  assign lk_index   = Address[TAG_LSB-1:IDX_LSB];
  assign lk_tag     = Address[ADDR_W-1:TAG_LSB];
  assign fill_word  = mem_addr_q[IDX_LSB-1:BYTE_OFF_W];
  assign fill_index = mem_addr_q[TAG_LSB-1:IDX_LSB];
  assign fill_tag   = mem_addr_q[ADDR_W-1:TAG_LSB];
  assign fill_last  = &fill_word;

  assign hit    = rd_valid && (rd_tag == lk_tag);
  assign lookup = (state_q == ST_IDLE) && (MemRead || MemWrite) && !RESET;

  dcache_line_store #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk        (CLK),
    .rst        (RESET),
    .rd_index   (lk_index),
    .rd_word    (lk_word),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .inv_en     (inv_en),
    .inv_index  (lk_index),
    .data_we    (data_we),
    .data_index (data_index),
    .data_word  (data_word),
    .data_wdata (data_wdata),
    .tag_we     (tag_we),
    .tag_index  (fill_index),
    .tag_wdata  (fill_tag)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    Stall       = 1'b0;
    Read_data   = '0;
    inv_en      = 1'b0;
    data_we     = 1'b0;
    data_index  = lk_index;
    data_word   = lk_word;
    data_wdata  = Write_Data;
    tag_we      = 1'b0;

    if (!RESET) begin
      unique case (state_q)
        ST_IDLE: begin
          if (MemWrite) begin
            Stall       = 1'b1;
            data_we     = hit;
            state_d     = ST_WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = Address & WORD_MASK;
            mem_wdata_d = Write_Data;
          end else if (MemRead) begin
            if (hit) begin
              Read_data = rd_data;
            end else begin
              // Invalidate up front so a fill abandoned midway can never produce a hit.
              Stall      = 1'b1;
              inv_en     = 1'b1;
              state_d    = ST_FILL;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = Address & LINE_MASK;
            end
          end
        end
        ST_FILL: begin
          Stall = 1'b1;
          if (mem.mem_ack) begin
            data_we    = 1'b1;
            data_index = fill_index;
            data_word  = fill_word;
            data_wdata = mem.mem_rdata;
            if (fill_last) begin
              tag_we    = 1'b1;
              mem_req_d = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              mem_addr_d = mem_addr_q + ADDR_W'(4);
            end
          end
        end
        ST_WRITE: begin
          Stall = 1'b1;
          if (mem.mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = ST_RESP;
          end
        end
        ST_RESP: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        relookup_q, relookup_d;

  // The IDLE cycle right after a fill re-presents the same load; it is not a new access.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    relookup_d = (state_q == ST_FILL) && mem.mem_ack && fill_last;
    if (lookup && !relookup_q) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      relookup_q <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      relookup_q <= relookup_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_lookup;
  assign unused_lookup = lookup;
`endif

endmodule
